intr_ctrl_n: RTL
================

// Module: intr_ctrl_n
// PURPOSE
//  N-source interrupt/exception controller; parametrised successor of the fixed 8-source InterruptSystem.
//  - Collects level requests from DSI/ISI/TLB/program/SC/device sources.
//  - Gates them by MSR, arbitrates by fixed priority and runs a four-phase req/ack per source.
//  - Presents exception code and vector (IVPR|IVOR) to the CU and returns the MSR update on acceptance.
//  - Owns IVPR and IVOR0..15 SPRs: one write port, two read ports.
// PARAMETERS
//  N_SRC      8              number of request channels; index 0 = highest priority
//  SRC_IVOR   {4,4,8,6,13,14,3,2}  packed N_SRC x 4b IVOR number per channel; ch0 in [3:0]
//  EE_MASK    8'b1100_0000   channels gated by MSR[EE] (external devices)
//  CE_MASK    8'b0000_0000   channels gated by MSR[CE] (critical class)
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        synchronous, active-high reset
//  src_req    in   N_SRC    level requests, one per channel
//  src_ack    out  N_SRC    one-hot acknowledge
//  msr        in   32       current MSR [0:31]; EE=bit16, PR=bit17, CE=bit14
//  intr_valid out  1        interrupt offered to CU
//  excep_code out  4        IVOR number of the granted channel
//  entry_addr out  32       {IVPR[0:15], IVOR[16:27], 4'b0}
//  cu_ack     in   1        CU accepts the offered interrupt
//  msr_wr     out  1        one-cycle MSR update strobe
//  msr_wd     out  32       MSR value to write
//  spr_waddr  in   10       SPR write address (sprn)
//  spr_wd     in   32       SPR write data
//  spr_wr     in   1        SPR write enable
//  spr_raddr0 in   10       read port 0 address
//  spr_raddr1 in   10       read port 1 address
//  spr_rd0    out  32       combinational read data, port 0
//  spr_rd1    out  32       combinational read data, port 1
// BEHAVIOUR
//  Reset: state IDLE; src_ack=0; intr_valid=0; excep_code=0; entry_addr=0; msr_wr=0; msr_wd=0; IVPR=0; all IVOR=0.
//  SPRs: IVPR at sprn 63; IVORk at sprn 400+k (k=0..15).
//   - Writes take effect at clk; writes to other addresses are ignored.
//   - Reads of unmapped addresses return 0. Read of an address written in the same cycle returns the old value.
//  Eligibility: elig = src_req & ~(EE_MASK & {N{~msr[16]}}) & ~(CE_MASK & {N{~msr[14]}}).
//  FSM:
//   IDLE    : if |elig, latch g = lowest set index; register excep_code = SRC_IVOR[g];
//             register entry_addr from the current (pre-write) IVPR/IVOR; -> OFFER.
//             Latency: req at cycle t -> intr_valid at t+1.
//   OFFER   : intr_valid=1; outputs held stable.
//             - cu_ack=1: src_ack[g]=1 next cycle; msr_wr pulses once with msr_wd = msr & ~(EE|PR), plus CE cleared
//               when g is in CE_MASK; -> HOLD.
//             - else if src_req[g]=0 (withdrawn): intr_valid drops next cycle, no ack, no msr_wr; -> IDLE.
//   HOLD    : intr_valid=0; src_ack[g] held high until src_req[g]=0, then src_ack[g]=0; -> IDLE. No new grant in the same cycle.
//  Simultaneous requests: lowest index wins; losers stay pending (level) and are served in later IDLE passes.
//  MSR change after the grant does not abort OFFER; gating applies in IDLE only.
//  cu_ack outside OFFER is ignored. Reset mid-handshake: all outputs return to reset values next cycle; no ack or msr_wr is emitted.
// STRUCTURE
//  Shared package intr_pkg.vh:
//   - SPRN_IVPR and SPRN_IVOR0..15 (from sprn_def.v)
//   - MSR bit indices EE/CE/PR
//   - ExcepCode_WIDTH=4
//   - state encodings S_IDLE/S_OFFER/S_HOLD
//  Sub-module ivor_file: 17x32 register file, 1W/2R, address decode included.
//  Top level holds the priority encoder (function), FSM and MSR-update logic.
// TESTING
//  1. Reset, write IVPR=0xFFFF_0000, IVOR2=0x120, IVOR4=0x500; read both ports same cycle
//     -> rd0/rd1 return the written values; raddr=401 returns 0 before its write, 0 when unmapped.
//  2. msr=0x0000_8000, src_req[0] pulse held high
//     -> next cycle intr_valid=1, excep_code=2, entry_addr=0xFFFF_0120;
//     -> cu_ack -> src_ack=0x01 and msr_wr with msr_wd=0x0000_0000; drop req -> ack drops the next cycle.
//  3. msr EE=0, src_req[6]=1 -> intr_valid stays 0 for 20 cycles; set EE=1 -> offer with code 4, entry 0xFFFF_0500.
//  4. src_req=0x41 simultaneously -> ch0 granted first; after its handshake ch6 is offered without re-asserting.
//  5. In OFFER, drop src_req[g] before cu_ack -> intr_valid falls, src_ack stays 0, msr_wr never pulses.
//  6. Assert rst during HOLD -> src_ack=0 next cycle; no msr_wr. Write IVOR2 in the grant cycle -> entry_addr uses the old IVOR2.

Source files
------------

// File: rtl/intr_ctrl_n_pkg.sv
// Shared constants for the N-source interrupt controller: SPR numbers, MSR bit
// positions, exception-code width, FSM encodings and the SPR address decode.
package intr_ctrl_n_pkg;

    localparam logic [9:0] SPRN_IVPR  = 10'd63;
    localparam logic [9:0] SPRN_IVOR0 = 10'd400;

    // MSR is documented big-endian [0:31]; these are the little-endian indices
    // into a [31:0] vector (EE=bit16 -> 15, PR=bit17 -> 14, CE=bit14 -> 17).
    localparam int MSR_EE = 15;
    localparam int MSR_PR = 14;
    localparam int MSR_CE = 17;

    localparam int EXCEP_CODE_WIDTH = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OFFER = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam int         N_SPR    = 17;
    localparam logic [4:0] IDX_IVPR = 5'd16;
    localparam logic [4:0] IDX_NONE = 5'd31;

    // Register-file slot for an sprn: 0..15 = IVORk, 16 = IVPR, IDX_NONE otherwise.
    function automatic logic [4:0] spr_index(input logic [9:0] sprn);
        logic [4:0] idx;
        idx = IDX_NONE;
        if (sprn == SPRN_IVPR)
            idx = IDX_IVPR;
        else if (sprn >= SPRN_IVOR0 && sprn <= SPRN_IVOR0 + 10'd15)
            idx = {1'b0, 4'(sprn - SPRN_IVOR0)};
        return idx;
    endfunction

endpackage

// File: rtl/intr_ctrl_n_ivor_file.sv
// IVPR + IVOR0..15 register file: one write port, two combinational read
// ports, plus a direct IVPR/IVOR lookup used to build the entry address.
module intr_ctrl_n_ivor_file
    import intr_ctrl_n_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        spr_wr,
    input  logic [9:0]  spr_waddr,
    input  logic [31:0] spr_wd,
    input  logic [9:0]  spr_raddr0,
    input  logic [9:0]  spr_raddr1,
    output logic [31:0] spr_rd0,
    output logic [31:0] spr_rd1,
    input  logic [3:0]  ivor_sel,
    output logic [31:0] ivpr_q,
    output logic [31:0] ivor_q
);

    logic [31:0] regs [N_SPR];
    logic [4:0]  widx;
    logic [4:0]  ridx0;
    logic [4:0]  ridx1;

    assign widx  = spr_index(spr_waddr);
    assign ridx0 = spr_index(spr_raddr0);
    assign ridx1 = spr_index(spr_raddr1);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SPR; i++) regs[i] <= '0;
        end else if (spr_wr && widx != IDX_NONE) begin
            regs[widx] <= spr_wd;
        end
    end

    // Reads see register contents, so a same-cycle write returns the old value.
    assign spr_rd0 = (ridx0 != IDX_NONE) ? regs[ridx0] : 32'h0;
    assign spr_rd1 = (ridx1 != IDX_NONE) ? regs[ridx1] : 32'h0;
    assign ivpr_q  = regs[IDX_IVPR];
    assign ivor_q  = regs[{1'b0, ivor_sel}];

endmodule

// File: rtl/intr_ctrl_n.sv
// N-source interrupt controller: MSR gating, fixed-priority grant, four-phase
// req/ack per channel, exception code/vector offer and MSR update on accept.
//
// state   | meaning
// S_IDLE  | waiting for an eligible request; latches grant, code and vector
// S_OFFER | intr_valid high, waiting for cu_ack or request withdrawal
// S_HOLD  | src_ack[g] high until the granted request drops
module intr_ctrl_n
    import intr_ctrl_n_pkg::*;
#(
    parameter int                  N_SRC    = 8,
    parameter logic [N_SRC*4-1:0]  SRC_IVOR = 32'h4486_DE32,
    parameter logic [N_SRC-1:0]    EE_MASK  = 8'b1100_0000,
    parameter logic [N_SRC-1:0]    CE_MASK  = 8'b0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_SRC-1:0]            src_req,
    output logic [N_SRC-1:0]            src_ack,
    input  logic [31:0]                 msr,
    output logic                        intr_valid,
    output logic [EXCEP_CODE_WIDTH-1:0] excep_code,
    output logic [31:0]                 entry_addr,
    input  logic                        cu_ack,
    output logic                        msr_wr,
    output logic [31:0]                 msr_wd,
    input  logic [9:0]                  spr_waddr,
    input  logic [31:0]                 spr_wd,
    input  logic                        spr_wr,
    input  logic [9:0]                  spr_raddr0,
    input  logic [9:0]                  spr_raddr1,
    output logic [31:0]                 spr_rd0,
    output logic [31:0]                 spr_rd1
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    function automatic logic [IDX_W-1:0] pri_enc(input logic [N_SRC-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    logic [1:0]       state;
    logic [IDX_W-1:0] grant;
    logic [N_SRC-1:0] elig;
    logic [IDX_W-1:0] win;
    logic [3:0]       win_code;
    logic [31:0]      ivpr_q;
    logic [31:0]      ivor_q;
    logic [31:0]      msr_clr;

    assign elig = src_req & ~(EE_MASK & {N_SRC{~msr[MSR_EE]}})
                          & ~(CE_MASK & {N_SRC{~msr[MSR_CE]}});
    assign win      = pri_enc(elig);
    assign win_code = SRC_IVOR[int'(win)*4 +: 4];

    always_comb begin
        msr_clr = '0;
        msr_clr[MSR_EE] = 1'b1;
        msr_clr[MSR_PR] = 1'b1;
        msr_clr[MSR_CE] = CE_MASK[grant];
    end

    intr_ctrl_n_ivor_file u_ivor_file (
        .clk        (clk),
        .rst        (rst),
        .spr_wr     (spr_wr),
        .spr_waddr  (spr_waddr),
        .spr_wd     (spr_wd),
        .spr_raddr0 (spr_raddr0),
        .spr_raddr1 (spr_raddr1),
        .spr_rd0    (spr_rd0),
        .spr_rd1    (spr_rd1),
        .ivor_sel   (win_code),
        .ivpr_q     (ivpr_q),
        .ivor_q     (ivor_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= '0;
            src_ack    <= '0;
            intr_valid <= 1'b0;
            excep_code <= '0;
            entry_addr <= '0;
            msr_wr     <= 1'b0;
            msr_wd     <= '0;
        end else begin
            msr_wr <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|elig) begin
                        grant      <= win;
                        excep_code <= win_code;
                        entry_addr <= {ivpr_q[31:16], ivor_q[15:4], 4'b0000};
                        intr_valid <= 1'b1;
                        state      <= S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (cu_ack) begin
                        src_ack    <= N_SRC'(1) << grant;
                        msr_wr     <= 1'b1;
                        msr_wd     <= msr & ~msr_clr;
                        intr_valid <= 1'b0;
                        state      <= S_HOLD;
                    end else if (!src_req[grant]) begin
                        intr_valid <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!src_req[grant]) begin
                        src_ack <= '0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
